banked_dmem: RTL
================

Name: banked_dmem

Overview:
- Parametrised successor of the core's byte-banked unified memory.
- NUM_BANKS byte-wide banks give a word of 8*NUM_BANKS bits; byte, half and word access at any byte address, spanning word boundaries natively.
- Adds valid/ready request handshake, READ_LAT-deep in-order response pipeline, per-access error flag, and self-clearing init FSM replacing file preload.
- Sits between core load/store unit and fetch arbiter.

Parameters:
NUM_BANKS, 4, byte banks per word; power of 2, 2..8; word width W = 8*NUM_BANKS
ADDR_W, 12, byte address width; DEPTH = 2**(ADDR_W - log2(NUM_BANKS)) words
READ_LAT, 1, accept-to-response latency in cycles, 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready at rising edge
req_we  in  1  1 = store, 0 = load
req_size  in  2  log2 bytes: 0 byte, 1 half, 2 word, 3 dword
req_addr  in  ADDR_W  byte address
req_wdata  in  W  store data; lane 0 (bits 7:0) goes to req_addr
rsp_valid  out  1  one-cycle response strobe, one per accepted request
rsp_rdata  out  W  load data; byte at req_addr in bits 7:0
rsp_err  out  1  request rejected, no side effect
init_done  out  1  high once clear sequence completes

Behaviour:
- Reset (async): FSM -> S_INIT, clear counter 0, pipeline flushed; rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_done=0.
- S_INIT: one word per cycle written to all-zero at counter; after word DEPTH-1 -> S_RUN. DEPTH cycles total; init_done and req_ready go high on the following edge.
- S_RUN: req_ready=1 every cycle; at most one request accepted per cycle; no stalls.
- Decode: off = addr[log2(NUM_BANKS)-1:0], waddr = addr >> log2(NUM_BANKS), nbytes = 1<<req_size.
- Lane mapping: bank b holds lane k = (b - off) mod NUM_BANKS. Bank row = waddr + 1 if b < off, else waddr. Row wraps modulo DEPTH, so the top address wraps to word 0.
- Store: bank b written with lane k of req_wdata iff k < nbytes. Committed at the accepting edge.
- Load: lanes k < nbytes returned rotated so byte at addr is in bits 7:0; lanes >= nbytes return 0. No sign extension; the core does that.
- Store response: rsp_rdata = 0.
- Error: nbytes > NUM_BANKS -> rsp_err=1, rsp_rdata=0, no write (plus macro case below).
- Latency: response data, err and valid are captured at the accept edge into a READ_LAT-stage shift pipeline. rsp_valid is asserted exactly READ_LAT cycles after acceptance. Responses are in order.
- Ordering: a load accepted the cycle after a store to overlapping bytes returns the new data. Back-to-back at full rate.
- Reset mid-operation: all in-flight responses dropped (no rsp_valid), memory re-cleared.

Optional Feature:
DMEM_MISALIGN_TRAP_EN:
- Defined: any access with off mod nbytes != 0 is rejected: rsp_err=1, no write, rdata 0.
- Undefined: misaligned accesses are served via bank row increment as above.

Test Plan:
- Assert rst 3 cycles, release; NUM_BANKS=4, ADDR_W=6 -> init_done/req_ready rise after 16 cycles. Load word 0x20 -> rsp_rdata 0x00000000, rsp_valid READ_LAT cycles after accept.
- Store word 0xDDCCBBAA @0x04, then load byte @0x06 next cycle -> 0x000000CC; load half @0x05 -> 0x0000CCBB.
- Macro off: store word 0x44332211 @0x0A -> load word @0x08 = 0x22110000, load word @0x0C = 0x00004433.
- Macro off: store half 0xBEEF @0x3F (wrap) -> load byte @0x3F = 0xEF, load byte @0x00 = 0xBE.
- req_size=3 store @0x00 -> rsp_err=1, word 0 unchanged. Macro on: load half @0x01 -> rsp_err=1, rdata 0.
- Load accepted, rst pulsed before response -> no rsp_valid for it, init restarts, previously written 0x04 reads 0 afterwards.

Source files
------------

// File: rtl/banked_dmem.sv
// ============================================================================
//  Module      : banked_dmem
//  Description : Byte-banked unified data memory. NUM_BANKS byte-wide banks
//                form one word of W = 8*NUM_BANKS bits. Byte, half, word and
//                dword accesses may start at any byte address and span word
//                boundaries natively (row wraps modulo DEPTH). Requests use
//                a valid/ready handshake; every accepted request produces
//                exactly one in-order response READ_LAT cycles later. After
//                reset a clear sequence zeroes the whole array before any
//                request is accepted.
//
//  Parameters  : NUM_BANKS - byte banks per word (power of 2, 2..8)
//                ADDR_W    - byte address width
//                READ_LAT  - accept-to-response latency, 1..4 cycles
//
//  Ports       : clk        in   clock, rising edge
//                rst        in   asynchronous reset, active-high
//                req_valid  in   request present
//                req_ready  out  request accepted when valid & ready
//                req_we     in   1 = store, 0 = load
//                req_size   in   log2 of byte count (0..3)
//                req_addr   in   byte address
//                req_wdata  in   store data, lane 0 goes to req_addr
//                rsp_valid  out  one-cycle response strobe
//                rsp_rdata  out  load data, byte at req_addr in bits 7:0
//                rsp_err    out  request rejected, no side effect
//                init_done  out  high once the clear sequence completes
//
//  Options     : define DMEM_MISALIGN_TRAP_EN to reject any access whose
//                byte offset is not a multiple of its size.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_dmem #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 12,
    parameter int READ_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [8*NUM_BANKS-1:0] req_wdata,
    output logic                   rsp_valid,
    output logic [8*NUM_BANKS-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   init_done
);

    localparam int c_W     = 8 * NUM_BANKS;
    localparam int c_OFF_W = $clog2(NUM_BANKS);
    localparam int c_ROW_W = ADDR_W - c_OFF_W;
    localparam int c_DEPTH = 1 << c_ROW_W;

    localparam logic [0:0] c_S_INIT = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // Storage: one byte array per bank, all rows of a bank in one vector
    // ------------------------------------------------------------------
    logic [7:0] r_mem [NUM_BANKS][c_DEPTH];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_ROW_W-1:0] r_clr_cnt;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic               w_accept;
    logic [c_OFF_W-1:0] w_off;
    logic [c_ROW_W-1:0] w_waddr;
    logic [3:0]         w_nbytes;
    logic               w_size_err;
    logic               w_err;

    assign req_ready = (r_state == c_S_RUN);
    assign init_done = (r_state == c_S_RUN);
    assign w_accept  = req_valid & req_ready;

    assign w_off      = req_addr[c_OFF_W-1:0];
    assign w_waddr    = req_addr[ADDR_W-1:c_OFF_W];
    assign w_nbytes   = 4'd1 << req_size;
    assign w_size_err = (w_nbytes > 4'(NUM_BANKS));

`ifdef DMEM_MISALIGN_TRAP_EN
    // nbytes is a power of two, so "off mod nbytes" is a mask of the low bits.
    // Only meaningful when nbytes <= NUM_BANKS; larger sizes already fail.
    logic w_misalign;
    assign w_misalign = ((4'(w_off) & (w_nbytes - 4'd1)) != 4'd0);
    assign w_err      = w_size_err | w_misalign;
`else
    assign w_err      = w_size_err;
`endif

    // ------------------------------------------------------------------
    // Store path: per bank, find which lane of req_wdata lands here and
    // which row it belongs to. Banks below the start offset belong to the
    // next row, so a misaligned access straddles two rows.
    // ------------------------------------------------------------------
    logic               w_bank_we    [NUM_BANKS];
    logic [c_ROW_W-1:0] w_bank_row   [NUM_BANKS];
    logic [7:0]         w_bank_wdata [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [c_OFF_W-1:0] w_lane;
        logic               w_wrap;

        // lane = (b - off) mod NUM_BANKS; truncation does the modulo
        assign w_lane = c_OFF_W'(b) - w_off;
        assign w_wrap = (c_OFF_W'(b) < w_off);

        // row addition wraps modulo DEPTH by truncation
        assign w_bank_row[b]   = w_waddr + c_ROW_W'(w_wrap);
        assign w_bank_we[b]    = w_accept & req_we & ~w_err &
                                 (4'(w_lane) < w_nbytes);
        assign w_bank_wdata[b] = req_wdata[{w_lane, 3'b000} +: 8];
    end

    // ------------------------------------------------------------------
    // Memory write port. While clearing, every bank writes zero at the
    // clear counter; requests cannot be accepted in that state, so the
    // two sources never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_state == c_S_INIT) begin
                r_mem[b][r_clr_cnt] <= 8'h00;
            end else if (w_bank_we[b]) begin
                r_mem[b][w_bank_row[b]] <= w_bank_wdata[b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: per output lane, pick the bank holding that byte.
    // Reads are combinational so that a load accepted the cycle after a
    // store sees the freshly written bytes with no forwarding logic.
    // ------------------------------------------------------------------
    logic [c_W-1:0] w_rdata;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_lane
        logic [c_OFF_W:0]   w_sum;
        logic [c_OFF_W-1:0] w_bank;
        logic [c_ROW_W-1:0] w_row;

        // bank = (k + off) mod NUM_BANKS; the carry selects the next row
        assign w_sum  = {1'b0, w_off} + (c_OFF_W + 1)'(k);
        assign w_bank = w_sum[c_OFF_W-1:0];
        assign w_row  = w_waddr + c_ROW_W'(w_sum[c_OFF_W]);

        assign w_rdata[8*k +: 8] = (4'(k) < w_nbytes) ? r_mem[w_bank][w_row]
                                                      : 8'h00;
    end

    // Stores and rejected requests always answer with zero data.
    logic [c_W-1:0] w_rsp_data;
    assign w_rsp_data = (req_we | w_err) ? '0 : w_rdata;

    // ------------------------------------------------------------------
    // Clear sequencer: one row per cycle, then run forever until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_INIT;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                c_S_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == c_ROW_W'(c_DEPTH - 1)) begin
                        r_state <= c_S_RUN;
                    end
                end
                default: begin
                    r_state <= c_S_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline. The response is fully formed at the accept edge
    // and then only delayed, so later stores cannot alter it. Data is
    // only loaded on accept, keeping rsp_rdata at zero between responses.
    // ------------------------------------------------------------------
    logic           r_pv [READ_LAT];
    logic           r_pe [READ_LAT];
    logic [c_W-1:0] r_pd [READ_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pe[0] <= w_accept & w_err;
            r_pd[0] <= w_accept ? w_rsp_data : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign rsp_valid = r_pv[READ_LAT-1];
    assign rsp_err   = r_pe[READ_LAT-1];
    assign rsp_rdata = r_pd[READ_LAT-1];

endmodule

`default_nettype wire
